// File: rtl/mult_hilo_pkg.sv
// mult_hilo_pkg: FSM encoding, operand/product widths and the carry-save helper for mult_hilo.
package mult_hilo_pkg;
  localparam int W  = 8;
  localparam int PW = 16;
  typedef enum logic [1:0] {IDLE, MUL, WB} state_t;
  typedef struct packed {
    logic [PW-1:0] s;
    logic [PW-1:0] c;
  } csa_t;
  function automatic csa_t csa(input logic [PW-1:0] x, y, z);
    csa.s = x ^ y ^ z;
    csa.c = ((x & y) | (x & z) | (y & z)) << 1;
  endfunction
endpackage

// File: rtl/mult_hilo_if.sv
// mult_hilo_if: request, register-write and HI/LO result signals of mult_hilo.
// Build with MULT_HILO_ACC_EN to add the acc request bit.
interface mult_hilo_if;
  import mult_hilo_pkg::*;
  logic         start;
  logic         sgn;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         mthi;
  logic         mtlo;
  logic [W-1:0] wdata;
  logic         busy;
  logic         done;
  logic [W-1:0] hi;
  logic [W-1:0] lo;
`ifdef MULT_HILO_ACC_EN
  logic         acc;
  modport master (output start, sgn, a, b, mthi, mtlo, wdata, acc, input busy, done, hi, lo);
  modport slave  (input start, sgn, a, b, mthi, mtlo, wdata, acc, output busy, done, hi, lo);
`else
  modport master (output start, sgn, a, b, mthi, mtlo, wdata, input busy, done, hi, lo);
  modport slave  (input start, sgn, a, b, mthi, mtlo, wdata, output busy, done, hi, lo);
`endif
endinterface

// File: rtl/mult_hilo_wallace.sv
// mult_hilo_wallace: 8x8 unsigned Wallace-tree multiplier, 16-bit product.
module mult_hilo_wallace
  import mult_hilo_pkg::*;
(
  input  logic [W-1:0]  a,
  input  logic [W-1:0]  b,
  output logic [PW-1:0] p
);
  logic [PW-1:0] pp [W];
  csa_t l1a, l1b, l2a, l2b, l3, l4;
  for (genvar i = 0; i < W; i++) begin : g_pp
    assign pp[i] = {PW{b[i]}} & (PW'(a) << i);
  end
  // 8 rows -> 6 -> 4 -> 3 -> 2, then one carry-propagate add
  assign l1a = csa(pp[0], pp[1], pp[2]);
  assign l1b = csa(pp[3], pp[4], pp[5]);
  assign l2a = csa(l1a.s, l1a.c, l1b.s);
  assign l2b = csa(l1b.c, pp[6], pp[7]);
  assign l3  = csa(l2a.s, l2a.c, l2b.s);
  assign l4  = csa(l3.s, l3.c, l2b.c);
  assign p   = l4.s + l4.c;
endmodule

// File: rtl/mult_hilo.sv
// mult_hilo: 3-cycle signed/unsigned 8x8 multiplier writing a HI/LO register pair.
// Optional MULT_HILO_ACC_EN adds accumulate-into-HI/LO.
module mult_hilo
  import mult_hilo_pkg::*;
(
  input logic        clk,
  input logic        rst,
  mult_hilo_if.slave m
);
  state_t        state_q, state_d;
  logic [W-1:0]  ma_q, ma_d, mb_q, mb_d;
  logic          neg_q, neg_d, done_q, done_d;
  logic [PW-1:0] prod_q, prod_d, hilo_q, hilo_d, p, sres, res;
  logic          idle, accept, wr;
`ifdef MULT_HILO_ACC_EN
  logic          acc_q, acc_d;
`endif
  mult_hilo_wallace u_wallace (.a(ma_q), .b(mb_q), .p(p));
  always_comb begin
    idle    = state_q == IDLE;
    accept  = idle & m.start;
    wr      = idle & ~m.start;
    state_d = accept ? MUL : state_q == MUL ? WB : IDLE;
    // magnitude of 0x80 is 0x80, i.e. 128 read unsigned
    ma_d    = accept ? (m.sgn & m.a[W-1] ? -m.a : m.a) : ma_q;
    mb_d    = accept ? (m.sgn & m.b[W-1] ? -m.b : m.b) : mb_q;
    neg_d   = accept ? m.sgn & (m.a[W-1] ^ m.b[W-1]) : neg_q;
    prod_d  = state_q == MUL ? p : prod_q;
    sres    = neg_q ? -prod_q : prod_q;
`ifdef MULT_HILO_ACC_EN
    acc_d   = accept ? m.acc : acc_q;
    res     = acc_q ? hilo_q + sres : sres;
`else
    res     = sres;
`endif
    hilo_d  = state_q == WB ? res :
              {wr & m.mthi ? m.wdata : hilo_q[PW-1:W], wr & m.mtlo ? m.wdata : hilo_q[W-1:0]};
    done_d  = state_q == WB;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      ma_q    <= '0;
      mb_q    <= '0;
      neg_q   <= 1'b0;
      prod_q  <= '0;
      hilo_q  <= '0;
      done_q  <= 1'b0;
`ifdef MULT_HILO_ACC_EN
      acc_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      ma_q    <= ma_d;
      mb_q    <= mb_d;
      neg_q   <= neg_d;
      prod_q  <= prod_d;
      hilo_q  <= hilo_d;
      done_q  <= done_d;
`ifdef MULT_HILO_ACC_EN
      acc_q   <= acc_d;
`endif
    end
  end
  assign m.busy = ~idle;
  assign m.done = done_q;
  assign m.hi   = hilo_q[PW-1:W];
  assign m.lo   = hilo_q[W-1:0];
endmodule

// File: tb/tb_mult_hilo.sv
// tb_mult_hilo: directed and random checks of mult_hilo against an integer-arithmetic model.
module tb_mult_hilo;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int ncmp = 0;
  int nerr = 0;
  logic [15:0] exp_hilo = '0;
`ifdef MULT_HILO_ACC_EN
  localparam bit ACC_ON = 1'b1;
`else
  localparam bit ACC_ON = 1'b0;
`endif
  mult_hilo_if m ();
  mult_hilo dut (.clk(clk), .rst(rst), .m(m));
  always #5 clk = ~clk;
  function automatic logic [15:0] model(input logic s, input logic [7:0] x, input logic [7:0] y);
    int sx, sy;
    sx = s ? int'($signed(x)) : int'(x);
    sy = s ? int'($signed(y)) : int'(y);
    return 16'(sx * sy);
  endfunction
  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    ncmp++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic run_mul(input logic s, input logic [7:0] x, input logic [7:0] y, input logic ac);
    logic [15:0] prev;
    prev = exp_hilo;
    m.start = 1'b1; m.sgn = s; m.a = x; m.b = y;
`ifdef MULT_HILO_ACC_EN
    m.acc = ac;
`endif
    tick();
    m.start = 1'b0;
    check("busy_mul", 16'(m.busy), 16'd1);
    check("done_mul", 16'(m.done), 16'd0);
    check("hilo_hold", {m.hi, m.lo}, prev);
    tick();
    check("done_wb", 16'(m.done), 16'd0);
    check("busy_wb", 16'(m.busy), 16'd1);
    exp_hilo = (ACC_ON && ac) ? exp_hilo + model(s, x, y) : model(s, x, y);
    tick();
    check("done", 16'(m.done), 16'd1);
    check("busy_idle", 16'(m.busy), 16'd0);
    check("product", {m.hi, m.lo}, exp_hilo);
  endtask
  initial begin
    m.start = 1'b0; m.sgn = 1'b0; m.a = '0; m.b = '0;
    m.mthi = 1'b0; m.mtlo = 1'b0; m.wdata = '0;
`ifdef MULT_HILO_ACC_EN
    m.acc = 1'b0;
`endif
    tick(); tick();
    check("rst_busy", 16'(m.busy), 16'd0);
    check("rst_done", 16'(m.done), 16'd0);
    check("rst_hilo", {m.hi, m.lo}, 16'h0000);
    rst = 1'b0;
    run_mul(1'b0, 8'd11, 8'd15, 1'b0);
    check("u11x15", {m.hi, m.lo}, 16'h00A5);
    run_mul(1'b1, 8'h80, 8'h80, 1'b0);
    check("s80x80", {m.hi, m.lo}, 16'h4000);
    run_mul(1'b1, 8'h64, 8'hFB, 1'b0);
    check("s100xm5", {m.hi, m.lo}, 16'hFE0C);
    run_mul(1'b0, 8'hFF, 8'hFF, 1'b0);
    check("uFFxFF", {m.hi, m.lo}, 16'hFE01);
    tick();
    check("done_one_cycle", 16'(m.done), 16'd0);
    // start held into MUL with new operands must not be taken
    m.start = 1'b1; m.sgn = 1'b0; m.a = 8'd5; m.b = 8'd5;
    tick();
    m.a = 8'd7; m.b = 8'd7;
    tick();
    m.start = 1'b0;
    check("busy_ign_done0", 16'(m.done), 16'd0);
    tick();
    exp_hilo = 16'h0019;
    check("busy_ign_done", 16'(m.done), 16'd1);
    check("busy_ign_res", {m.hi, m.lo}, 16'h0019);
    tick();
    check("not_queued_busy", 16'(m.busy), 16'd0);
    check("not_queued_done", 16'(m.done), 16'd0);
    run_mul(1'b0, 8'd3, 8'd4, 1'b0);
    run_mul(1'b0, 8'd6, 8'd9, 1'b0);
    check("b2b", {m.hi, m.lo}, 16'd54);
    m.start = 1'b1; m.sgn = 1'b0; m.a = 8'd100; m.b = 8'd5;
    tick();
    m.start = 1'b0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    exp_hilo = '0;
    check("rstmid_busy", 16'(m.busy), 16'd0);
    check("rstmid_done", 16'(m.done), 16'd0);
    check("rstmid_hilo", {m.hi, m.lo}, 16'h0000);
    tick();
    check("rstmid_nodone1", 16'(m.done), 16'd0);
    tick();
    check("rstmid_nodone2", 16'(m.done), 16'd0);
    m.mthi = 1'b1; m.wdata = 8'h12;
    tick();
    m.mthi = 1'b0; m.mtlo = 1'b1; m.wdata = 8'h34;
    tick();
    m.mtlo = 1'b0;
    exp_hilo = 16'h1234;
    check("mthi_mtlo", {m.hi, m.lo}, 16'h1234);
    // mthi alongside start, then mtlo while busy: both dropped
    m.start = 1'b1; m.mthi = 1'b1; m.wdata = 8'hAA; m.a = 8'd3; m.b = 8'd3;
    tick();
    m.start = 1'b0; m.mthi = 1'b0; m.mtlo = 1'b1; m.wdata = 8'h55;
    check("mthi_with_start", {m.hi, m.lo}, 16'h1234);
    tick();
    m.mtlo = 1'b0;
    check("mtlo_busy", {m.hi, m.lo}, 16'h1234);
    tick();
    exp_hilo = 16'd9;
    check("after_busy_wr", {m.hi, m.lo}, 16'd9);
    m.mthi = 1'b1; m.mtlo = 1'b1; m.wdata = 8'h77;
    tick();
    m.mthi = 1'b0; m.mtlo = 1'b0;
    exp_hilo = 16'h7777;
    check("both_wr", {m.hi, m.lo}, 16'h7777);
    rst = 1'b1; m.start = 1'b1; m.mthi = 1'b1; m.wdata = 8'h99;
    tick();
    rst = 1'b0; m.start = 1'b0; m.mthi = 1'b0;
    exp_hilo = '0;
    check("rst_prio_hilo", {m.hi, m.lo}, 16'h0000);
    check("rst_prio_busy", 16'(m.busy), 16'd0);
`ifdef MULT_HILO_ACC_EN
    run_mul(1'b0, 8'd21, 8'd35, 1'b0);
    run_mul(1'b0, 8'd100, 8'd5, 1'b1);
    check("acc_1235", {m.hi, m.lo}, 16'h04D3);
`endif
    for (int i = 0; i < 40; i++)
      run_mul(1'($urandom_range(0, 1)), 8'($urandom), 8'($urandom), ACC_ON & 1'($urandom_range(0, 1)));
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
    $finish;
  end
endmodule

// File: doc/mult_hilo.md
MULT_HILO -- requirements
Module: mult_hilo

Interface
REQ-001 Parameters: none; operand width is fixed at 8 to match the existing wallace multiplier.
REQ-002 clk  input  1  single clock; all state changes on rising edge.
REQ-003 rst  input  1  reset, synchronous, active-high.
REQ-004 start  input  1  request a multiply; sampled only when busy=0.
REQ-005 sgn  input  1  1 = signed two's-complement operands, 0 = unsigned; sampled with start.
REQ-006 a  input  8  multiplicand; sampled with start.
REQ-007 b  input  8  multiplier; sampled with start.
REQ-008 mthi  input  1  write wdata into HI when idle.
REQ-009 mtlo  input  1  write wdata into LO when idle.
REQ-010 wdata  input  8  data for mthi/mtlo.
REQ-011 busy  output  1  high while a multiply is in flight.
REQ-012 done  output  1  one-cycle pulse when HI/LO hold a new product.
REQ-013 hi  output  8  upper product byte register.
REQ-014 lo  output  8  lower product byte register.

Function
REQ-015 FSM states SHALL be IDLE, MUL and WB; reset state is IDLE.
REQ-016 IDLE with start=1 at edge E0: capture |a| and |b| (magnitudes when sgn=1, raw when sgn=0), capture neg = sgn & (a[7]^b[7]), go to MUL.
REQ-017 MUL at edge E1: register the 16-bit wallace product of the captured magnitudes, go to WB.
REQ-018 WB at edge E2: {hi,lo} <= neg ? two's-complement negation of the product : product; done <= 1; go to IDLE.
REQ-019 done SHALL be high for exactly the one cycle after E2 and low otherwise.
REQ-020 busy SHALL be high in MUL and WB, and low in IDLE.
REQ-021 start while busy=1 SHALL be ignored; it is not queued.
REQ-022 Back-to-back: start in the cycle where done=1 (IDLE) SHALL be accepted; throughput is one multiply per 3 cycles.
REQ-023 Magnitude of 0x80 signed is 128, which is carried unsigned in 8 bits; -128*-128 = 0x4000.
REQ-024 Products are exact in 16 bits for all inputs: unsigned max 0xFE01; signed range -16256..16384.
REQ-025 mthi/mtlo SHALL write only in IDLE with start=0; both asserted writes both registers.
REQ-026 mthi/mtlo asserted while busy, or together with start, SHALL be ignored.
REQ-027 hi and lo SHALL be stable except at the WB edge or at an accepted mthi/mtlo edge.

Reset
REQ-028 rst=1 at any edge, including mid-operation, SHALL force IDLE, hi=lo=0x00, busy=0, done=0, and discard the in-flight product.
REQ-029 rst SHALL take priority over start, mthi and mtlo in the same cycle.

Configuration
REQ-030 Macro MULT_HILO_ACC_EN SHALL control the accumulate feature.
REQ-031 With MULT_HILO_ACC_EN defined:
- Add input port acc (1 bit), sampled with start.
- acc=1: at WB, {hi,lo} <= {hi,lo} + signed product, modulo 2^16.
- acc=0: product overwrites {hi,lo}.
REQ-032 Without MULT_HILO_ACC_EN: the acc port is absent and the product always overwrites {hi,lo}.

Structure
REQ-033 A shared package SHALL hold the FSM state encoding and the 8/16 width constants.
REQ-034 One sub-module SHALL be the existing wallace multiplier (8x8 -> 16), instanced once with ports a, b, p.
REQ-035 All other logic (sign handling, FSM, HI/LO) SHALL live in mult_hilo.

Verification
REQ-036 Unsigned: sgn=0, a=11, b=15, start -> done 3 edges later; hi=0x00, lo=0xA5.
REQ-037 Signed extremes:
- sgn=1, a=0x80, b=0x80 -> hi:lo=0x4000.
- sgn=1, a=0x64, b=0xFB -> hi:lo=0xFE0C (-500).
- sgn=0, a=0xFF, b=0xFF -> hi:lo=0xFE01.
REQ-038 Busy handling:
- start 5*5, then start 7*7 one cycle later -> second start ignored; result 0x0019; single done pulse.
- Start in the done cycle -> accepted.
REQ-039 Reset mid-operation: start 100*5, assert rst in MUL -> hi:lo=0x0000, done never pulses, busy=0 the cycle after.
REQ-040 Register writes:
- mthi wdata=0x12 then mtlo wdata=0x34 in IDLE -> hi:lo=0x1234.
- mtlo during busy -> lo unchanged.
REQ-041 With MULT_HILO_ACC_EN: 21*35 (acc=0), then 100*5 (acc=1) -> hi:lo=0x04D3 (1235).
